// File: rtl/ahb_lite_mem_slave.sv
// rtl/ahb_lite_mem_slave.sv - AHB-Lite memory responder with programmable wait states and ERROR response
module ahb_lite_mem_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  Hsel,
    input  logic [ADDR_WIDTH-1:0] Haddr,
    input  logic [1:0]            Htrans,
    input  logic                  Hwrite,
    input  logic [2:0]            Hsize,
    input  logic [2:0]            Hburst,
    input  logic [3:0]            Hprot,
    input  logic                  Hmastlock,
    input  logic [DATA_WIDTH-1:0] Hwdata,
    input  logic                  Hready_in,
    output logic                  Hready_out,
    output logic                  Hresp,
    output logic [DATA_WIDTH-1:0] Hrdata
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(BYTES);
    localparam int IDX_BITS  = $clog2(MEM_DEPTH);
    localparam int QA_BITS   = LANE_BITS + IDX_BITS;
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * BYTES);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t               state, state_n;
    logic [3:0]           cnt, cnt_n;
    logic [QA_BITS-1:0]   addr_q;
    logic                 write_q;
    logic [2:0]           size_q;
    logic                 load;
    logic                 free;
    logic                 do_write;
    logic                 do_read;

    logic                 capture;
    logic [7:0]           size_mask;
    logic                 bad_access;
    logic                 last;
    logic [IDX_BITS-1:0]  widx;
    logic [3:0]           lane_lo;
    logic [3:0]           lane_hi;
    logic [BYTES-1:0]     lane_en;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Burst type, protection and lock are accepted on the bus but carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{Hburst, Hprot, Hmastlock};

    // Address-phase decode: a transfer is taken only on NONSEQ/SEQ while the bus is ready.
    always_comb begin
        capture    = Hsel & Hready_in & Htrans[1];
        size_mask  = 8'((9'd1 << Hsize) - 9'd1);
        bad_access = ({1'b0, Haddr} >= MEM_BYTES)
                   | (Hsize > 3'(LANE_BITS))
                   | (|(Haddr[7:0] & size_mask));
        last       = (cnt == 4'(WAIT_STATES));
        widx       = addr_q[QA_BITS-1:LANE_BITS];
        lane_lo    = 4'(addr_q[LANE_BITS-1:0]);
        lane_hi    = lane_lo + (4'd1 << size_q);
    end

    // Byte-lane enables for the captured write: little-endian lanes from the low address bits.
    always_comb begin
        lane_en = '0;
        for (int i = 0; i < BYTES; i++) begin
            lane_en[i] = (4'(i) >= lane_lo) && (4'(i) < lane_hi);
        end
    end

    // State register plus captured address-phase controls.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (load) begin
                addr_q  <= Haddr[QA_BITS-1:0];
                write_q <= Hwrite;
                size_q  <= Hsize;
            end
        end
    end

    // Next state and bus response; IDLE, ERR2 and the last DATA cycle may accept a new transfer.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        load       = 1'b0;
        free       = 1'b0;
        do_write   = 1'b0;
        do_read    = 1'b0;
        Hready_out = 1'b1;
        Hresp      = 1'b0;
        case (state)
            S_IDLE: free = 1'b1;
            S_DATA: begin
                if (last) begin
                    free     = 1'b1;
                    do_write = write_q;
                    do_read  = ~write_q;
                end else begin
                    Hready_out = 1'b0;
                    cnt_n      = cnt + 4'd1;
                end
            end
            S_ERR1: begin
                Hready_out = 1'b0;
                Hresp      = 1'b1;
                state_n    = S_ERR2;
            end
            S_ERR2: begin
                Hresp = 1'b1;
                free  = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
        if (free) begin
            cnt_n = 4'd0;
            if (capture) begin
                state_n = bad_access ? S_ERR1 : S_DATA;
                load    = ~bad_access;
            end else begin
                state_n = S_IDLE;
            end
        end
    end

    // Read data is driven only in the completing cycle of a read; zero otherwise.
    always_comb begin
        Hrdata = '0;
        if (do_read) begin
            Hrdata = mem[widx];
        end
    end

    // Memory array is deliberately not reset so contents survive hreset.
    always_ff @(posedge hclk) begin
        if (do_write) begin
            for (int i = 0; i < BYTES; i++) begin
                if (lane_en[i]) begin
                    mem[widx][i*8 +: 8] <= Hwdata[i*8 +: 8];
                end
            end
        end
    end

endmodule
